decode_queue: RTL

//  Buffered decode stage between instruction fetch and issue. Decodes each RV32I word on push
//  and stores decoded fields in a DEPTH-entry circular FIFO; issue pops one per cycle.

---
 rtl/decode_queue_pkg.sv | 54 +++++
 rtl/decode_queue_decode_core.sv | 119 +++++++++++
 rtl/decode_queue.sv | 131 +++++++++++++
 3 files changed

// File: rtl/decode_queue_pkg.sv
// Shared RV32I decode types: opcode constants, decoded-op encoding and
// the decoded-entry record stored in every queue slot.
package decode_queue_pkg;

  localparam int OP_W = 6;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // OP_NONE is the all-zero code shown on out_op while the queue is empty.
  typedef enum logic [OP_W-1:0] {
    OP_NONE,
    OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
    OP_SB, OP_SH, OP_SW,
    OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
    OP_SLLI, OP_SRLI, OP_SRAI,
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
    OP_ILLEGAL
  } op_e;

  typedef struct packed {
    op_e         op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        is_ls;
    logic        is_store;
    logic        is_branch;
    logic        illegal;
  } dec_t;

  // Canonical record for a bad encoding: everything cleared except the flag.
  function automatic dec_t illegal_dec();
    dec_t d;
    d         = '0;
    d.op      = OP_ILLEGAL;
    d.illegal = 1'b1;
    return d;
  endfunction

endpackage

// File: rtl/decode_queue_decode_core.sv
// Purely combinational RV32I decoder: raw word -> decoded entry, with strict
// funct3/funct7 legality checking.
module inst_decode_core
  import decode_queue_pkg::*;
(
  input  logic [31:0] inst_i,
  output dec_t        dec_o
);

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] i_imm, s_imm, b_imm, j_imm, u_imm, sh_imm;
  logic        legal;
  logic        alt;
  dec_t        dec_d;

  assign opcode = inst_i[6:0];
  assign f3     = inst_i[14:12];
  assign f7     = inst_i[31:25];
  assign alt    = (f7 == F7_ALT);
  assign i_imm  = {{20{inst_i[31]}}, inst_i[31:20]};
  assign s_imm  = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
  assign b_imm  = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
  assign j_imm  = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
  assign u_imm  = {inst_i[31:12], 12'b0};
  assign sh_imm = {27'b0, inst_i[24:20]};

  // Decode fields per format, then replace the whole record if illegal.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
    dec_d = '0;
    legal = 1'b1;
    case (opcode)
      OPC_LUI:   begin dec_d.op = OP_LUI;   dec_d.rd = inst_i[11:7]; dec_d.imm = u_imm; end
      OPC_AUIPC: begin dec_d.op = OP_AUIPC; dec_d.rd = inst_i[11:7]; dec_d.imm = u_imm; end
      OPC_JAL: begin
        dec_d.op = OP_JAL; dec_d.rd = inst_i[11:7]; dec_d.imm = j_imm; dec_d.is_branch = 1'b1;
      end
      OPC_JALR: begin
        dec_d.op = OP_JALR; dec_d.rd = inst_i[11:7]; dec_d.rs1 = inst_i[19:15];
        dec_d.imm = i_imm; dec_d.is_branch = 1'b1;
      end
      OPC_BRANCH: begin
        dec_d.rs1 = inst_i[19:15]; dec_d.rs2 = inst_i[24:20];
        dec_d.imm = b_imm; dec_d.is_branch = 1'b1;
        case (f3)
          3'b000:  dec_d.op = OP_BEQ;
          3'b001:  dec_d.op = OP_BNE;
          3'b100:  dec_d.op = OP_BLT;
          3'b101:  dec_d.op = OP_BGE;
          3'b110:  dec_d.op = OP_BLTU;
          3'b111:  dec_d.op = OP_BGEU;
          default: legal = 1'b0;
        endcase
      end
      OPC_LOAD: begin
        dec_d.rd = inst_i[11:7]; dec_d.rs1 = inst_i[19:15];
        dec_d.imm = i_imm; dec_d.is_ls = 1'b1;
        case (f3)
          3'b000:  dec_d.op = OP_LB;
          3'b001:  dec_d.op = OP_LH;
          3'b010:  dec_d.op = OP_LW;
          3'b100:  dec_d.op = OP_LBU;
          3'b101:  dec_d.op = OP_LHU;
          default: legal = 1'b0;
        endcase
      end
      OPC_STORE: begin
        dec_d.rs1 = inst_i[19:15]; dec_d.rs2 = inst_i[24:20];
        dec_d.imm = s_imm; dec_d.is_ls = 1'b1; dec_d.is_store = 1'b1;
        case (f3)
          3'b000:  dec_d.op = OP_SB;
          3'b001:  dec_d.op = OP_SH;
          3'b010:  dec_d.op = OP_SW;
          default: legal = 1'b0;
        endcase
      end
      OPC_OP_IMM: begin
        dec_d.rd = inst_i[11:7]; dec_d.rs1 = inst_i[19:15]; dec_d.imm = i_imm;
        case (f3)
          3'b000: dec_d.op = OP_ADDI;
          3'b010: dec_d.op = OP_SLTI;
          3'b011: dec_d.op = OP_SLTIU;
          3'b100: dec_d.op = OP_XORI;
          3'b110: dec_d.op = OP_ORI;
          3'b111: dec_d.op = OP_ANDI;
          3'b001: begin
            dec_d.op = OP_SLLI; dec_d.imm = sh_imm; legal = (f7 == F7_ZERO);
          end
          default: begin
            dec_d.op = alt ? OP_SRAI : OP_SRLI; dec_d.imm = sh_imm;
            legal = (f7 == F7_ZERO) || alt;
          end
        endcase
      end
      OPC_OP: begin
        dec_d.rd = inst_i[11:7]; dec_d.rs1 = inst_i[19:15]; dec_d.rs2 = inst_i[24:20];
        // Only ADD/SUB and SRL/SRA have an alternate funct7 form.
        legal = (f7 == F7_ZERO) || (alt && (f3 == 3'b000 || f3 == 3'b101));
        case (f3)
          3'b000:  dec_d.op = alt ? OP_SUB : OP_ADD;
          3'b001:  dec_d.op = OP_SLL;
          3'b010:  dec_d.op = OP_SLT;
          3'b011:  dec_d.op = OP_SLTU;
          3'b100:  dec_d.op = OP_XOR;
          3'b101:  dec_d.op = alt ? OP_SRA : OP_SRL;
          3'b110:  dec_d.op = OP_OR;
          default: dec_d.op = OP_AND;
        endcase
      end
      default: legal = 1'b0;
    endcase
    if (!legal) dec_d = illegal_dec();
  end

  assign dec_o = dec_d;

endmodule

// File: rtl/decode_queue.sv
// Buffered decode stage: words are decoded on push and parked in a circular
// FIFO; issue pops the head. Supports freeze (rdy_in low) and flush.
module decode_queue
  import decode_queue_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 32
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   rdy_in,
  input  logic                   flush_in,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_inst,
  input  logic [ADDR_W-1:0]      in_pc,
  input  logic                   in_pred_taken,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OP_W-1:0]        out_op,
  output logic [4:0]             out_rd,
  output logic [4:0]             out_rs1,
  output logic [4:0]             out_rs2,
  output logic [31:0]            out_imm,
  output logic [ADDR_W-1:0]      out_pc,
  output logic                   out_pred_taken,
  output logic                   out_is_ls,
  output logic                   out_is_store,
  output logic                   out_is_branch,
  output logic                   out_illegal,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  dec_t              dec_in;
  dec_t              dec_mem_q  [DEPTH];
  logic [ADDR_W-1:0] pc_mem_q   [DEPTH];
  logic              pred_mem_q [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push, pop, not_empty;
  dec_t              head_dec;

  inst_decode_core u_core (
    .inst_i (in_inst),
    .dec_o  (dec_in)
  );

  assign not_empty = (count_q != '0);
  assign in_ready  = !rst_in && rdy_in && (count_q != CNT_W'(DEPTH));
  assign out_valid = !rst_in && rdy_in && not_empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Next-state pointers/occupancy: flush beats push/pop, freeze beats flush.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (rdy_in) begin
      if (flush_in) begin
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
      end else begin
        if (push) tail_d = tail_q + PTR_W'(1);
        if (pop)  head_d = head_q + PTR_W'(1);
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

  // Control registers with synchronous reset.
  always_ff @(posedge clk_in) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst_in) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage written at the tail on an accepted push.
  always_ff @(posedge clk_in) begin
    // NOTE: storage is deliberately not reset; count_q gates every read, so stale slots are never visible.
    if (push && !flush_in) begin
      dec_mem_q[tail_q]  <= dec_in;
      pc_mem_q[tail_q]   <= in_pc;
      pred_mem_q[tail_q] <= in_pred_taken;
    end
  end

  assign head_dec = dec_mem_q[head_q];

  // Head entry presented combinationally; all zero while empty.
  always_comb begin
    out_op         = '0;
    out_rd         = '0;
    out_rs1        = '0;
    out_rs2        = '0;
    out_imm        = '0;
    out_pc         = '0;
    out_pred_taken = 1'b0;
    out_is_ls      = 1'b0;
    out_is_store   = 1'b0;
    out_is_branch  = 1'b0;
    out_illegal    = 1'b0;
    if (not_empty) begin
      out_op         = head_dec.op;
      out_rd         = head_dec.rd;
      out_rs1        = head_dec.rs1;
      out_rs2        = head_dec.rs2;
      out_imm        = head_dec.imm;
      out_pc         = pc_mem_q[head_q];
      out_pred_taken = pred_mem_q[head_q];
      out_is_ls      = head_dec.is_ls;
      out_is_store   = head_dec.is_store;
      out_is_branch  = head_dec.is_branch;
      out_illegal    = head_dec.illegal;
    end
  end

  assign count = count_q;

endmodule
